// File: rtl/game_sched_pkg.sv
// Shared definitions for the sprite update scheduler.
//   - One-hot state encodings (5 bits) and the state enum built on them.
//   - Bit positions inside the registered op vector (xy load, dxy load, move).
//   - idx_w(): sprite index width for a given sprite count (clog2, minimum 1).
package game_sched_pkg;

  localparam logic [4:0] ST_IDLE  = 5'b00001;
  localparam logic [4:0] ST_LOAD  = 5'b00010;
  localparam logic [4:0] ST_SCAN  = 5'b00100;
  localparam logic [4:0] ST_CHECK = 5'b01000;
  localparam logic [4:0] ST_DONE  = 5'b10000;

  typedef enum logic [4:0] {
    S_IDLE  = ST_IDLE,
    S_LOAD  = ST_LOAD,
    S_SCAN  = ST_SCAN,
    S_CHECK = ST_CHECK,
    S_DONE  = ST_DONE
  } state_t;

  localparam int OP_XY   = 0;
  localparam int OP_DXY  = 1;
  localparam int OP_MOVE = 2;
  localparam int OP_W    = 3;

  function automatic int idx_w(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/game_sched_prio_pick.sv
// Combinational lowest-set-bit finder restricted to indices >= start.
//   req   : candidate bits
//   start : first index eligible (one bit wider than idx so "past the end"
//           can be expressed without wrapping)
//   found : some eligible bit is set
//   idx   : lowest eligible set index (0 when nothing found)
module game_sched_prio_pick #(
  parameter int WIDTH = 2,
  parameter int IDX_W = 1
) (
  input  logic [WIDTH-1:0] req,
  input  logic [IDX_W:0]   start,
  output logic             found,
  output logic [IDX_W-1:0] idx
);

  // Walk from the top down so the lowest qualifying index is written last.
  always_comb begin
    found = 1'b0;
    idx   = '0;
    for (int i = WIDTH - 1; i >= 0; i--) begin
      if (req[i] && (i >= int'(start))) begin
        found = 1'b1;
        idx   = IDX_W'(i);
      end
    end
  end

endmodule

// File: rtl/game_sprite_update_scheduler.sv
// Per-frame sequencer sharing one sprite-update datapath among N_SPRITES.
// A frame is one slot per sprite index (SCAN), then a collision-check strobe,
// then a frame-done strobe. Between frames, pending position/velocity writes
// are drained one sprite at a time through LOAD slots.
//
// Ports:
//   clk, reset       clock, asynchronous active-high reset
//   frame_tick       one-cycle pulse per video frame
//   write_xy_req     per-sprite pulse, load start position
//   write_dxy_req    per-sprite pulse, load velocity
//   enable_update    per-sprite level, sprite moves each frame
//   upd_valid        slot active this cycle
//   upd_index        sprite owning the slot
//   upd_write_xy     slot loads xy
//   upd_write_dxy    slot loads dxy
//   upd_move         slot adds dxy to xy
//   check_collision  one-cycle strobe after the last slot
//   frame_done       one-cycle strobe ending the frame
//   busy             scheduler not idle
//   overrun          one-cycle pulse when a frame_tick is dropped
//
// Build option GAME_SCHED_SKIP_DISABLED_EN: SCAN visits only sprites that
// are enabled or have a pending write; with none, a frame is CHECK + DONE.
// Without it every index gets a slot and a frame is N_SPRITES+2 cycles.
module game_sprite_update_scheduler
  import game_sched_pkg::*;
#(
  parameter int N_SPRITES = 2,
  parameter int IDX_W     = idx_w(N_SPRITES)
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 frame_tick,
  input  logic [N_SPRITES-1:0] write_xy_req,
  input  logic [N_SPRITES-1:0] write_dxy_req,
  input  logic [N_SPRITES-1:0] enable_update,
  output logic                 upd_valid,
  output logic [IDX_W-1:0]     upd_index,
  output logic                 upd_write_xy,
  output logic                 upd_write_dxy,
  output logic                 upd_move,
  output logic                 check_collision,
  output logic                 frame_done,
  output logic                 busy,
  output logic                 overrun
);

  state_t                 state, nstate;
  logic [IDX_W-1:0]       idx, nidx;
  logic [N_SPRITES-1:0]   pend_xy, pend_dxy, clr;
  logic                   tick_pending;
  logic                   frame_start, issue;
  logic [OP_W-1:0]        op_d, op_q;

  // LOAD drains the lowest sprite with any pending write.
  logic                   ld_found;
  logic [IDX_W-1:0]       ld_idx;

  game_sched_prio_pick #(.WIDTH(N_SPRITES), .IDX_W(IDX_W)) u_load_pick (
    .req   (pend_xy | pend_dxy),
    .start ('0),
    .found (ld_found),
    .idx   (ld_idx)
  );

  // scan_go/scan_idx: the next SCAN slot, searched from 0 when a frame starts
  // and from idx+1 while scanning.
  logic                   scan_go;
  logic [IDX_W-1:0]       scan_idx;

`ifdef GAME_SCHED_SKIP_DISABLED_EN
  logic [IDX_W:0]         sc_start;

  assign sc_start = (state == S_SCAN) ? ({1'b0, idx} + (IDX_W+1)'(1)) : '0;

  game_sched_prio_pick #(.WIDTH(N_SPRITES), .IDX_W(IDX_W)) u_scan_pick (
    .req   (enable_update | pend_xy | pend_dxy),
    .start (sc_start),
    .found (scan_go),
    .idx   (scan_idx)
  );
`else
  assign scan_go  = (state == S_SCAN) ? (idx != IDX_W'(N_SPRITES - 1)) : 1'b1;
  assign scan_idx = (state == S_SCAN) ? (idx + IDX_W'(1)) : '0;
`endif

  always_comb begin
    nstate      = state;
    nidx        = idx;
    frame_start = 1'b0;
    case (state)
      S_IDLE: begin
        if (frame_tick || tick_pending) begin
          frame_start = 1'b1;
        end else if (ld_found) begin
          nstate = S_LOAD;
          nidx   = ld_idx;
        end
      end
      S_LOAD:  nstate = S_IDLE;
      S_SCAN: begin
        if (scan_go) nidx = scan_idx;
        else         nstate = S_CHECK;
      end
      S_CHECK: nstate = S_DONE;
      // A tick that arrived during the frame restarts SCAN with no idle gap.
      S_DONE: begin
        if (tick_pending) frame_start = 1'b1;
        else              nstate = S_IDLE;
      end
      default: nstate = S_IDLE;
    endcase

    if (frame_start) begin
      if (scan_go) begin
        nstate = S_SCAN;
        nidx   = scan_idx;
      end else begin
        nstate = S_CHECK;
      end
    end

    // Outputs are registered from the next state, so the slot shown in a
    // cycle samples the pending bits at the edge that opens it; that same
    // edge clears them.
    issue = (nstate == S_LOAD) || (nstate == S_SCAN);
    clr   = '0;
    op_d  = '0;
    if (issue) begin
      clr[nidx]     = 1'b1;
      op_d[OP_XY]   = pend_xy[nidx];
      op_d[OP_DXY]  = pend_dxy[nidx];
      op_d[OP_MOVE] = (nstate == S_SCAN) && enable_update[nidx] && !pend_xy[nidx];
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state           <= S_IDLE;
      idx             <= '0;
      pend_xy         <= '0;
      pend_dxy        <= '0;
      tick_pending    <= 1'b0;
      upd_valid       <= 1'b0;
      upd_index       <= '0;
      op_q            <= '0;
      check_collision <= 1'b0;
      frame_done      <= 1'b0;
      busy            <= 1'b0;
      overrun         <= 1'b0;
    end else begin
      state           <= nstate;
      idx             <= nidx;
      // Set wins over the clear of the slot being issued.
      pend_xy         <= (pend_xy & ~clr) | write_xy_req;
      pend_dxy        <= (pend_dxy & ~clr) | write_dxy_req;
      // Only one tick can be held; a second one is dropped and flagged.
      if (frame_start)     tick_pending <= 1'b0;
      else if (frame_tick) tick_pending <= 1'b1;
      upd_valid       <= issue;
      upd_index       <= issue ? nidx : '0;
      op_q            <= op_d;
      check_collision <= (nstate == S_CHECK);
      frame_done      <= (nstate == S_DONE);
      busy            <= (nstate != S_IDLE);
      overrun         <= frame_tick && tick_pending;
    end
  end

  assign upd_write_xy  = op_q[OP_XY];
  assign upd_write_dxy = op_q[OP_DXY];
  assign upd_move      = op_q[OP_MOVE];

endmodule

// File: tb/tb_game_sprite_update_scheduler.sv
// Bench for game_sprite_update_scheduler with N_SPRITES=2: a table of
// directed cycles, an asynchronous reset mid-frame, then randomized traffic
// checked against a frame-level reference model.
module tb_game_sprite_update_scheduler;

  localparam int N = 2;

  logic         clk, reset, frame_tick;
  logic [N-1:0] write_xy_req, write_dxy_req, enable_update;
  logic         upd_valid, upd_write_xy, upd_write_dxy, upd_move;
  logic [0:0]   upd_index;
  logic         check_collision, frame_done, busy, overrun;

  game_sprite_update_scheduler #(.N_SPRITES(N), .IDX_W(1)) dut (
    .clk             (clk),
    .reset           (reset),
    .frame_tick      (frame_tick),
    .write_xy_req    (write_xy_req),
    .write_dxy_req   (write_dxy_req),
    .enable_update   (enable_update),
    .upd_valid       (upd_valid),
    .upd_index       (upd_index),
    .upd_write_xy    (upd_write_xy),
    .upd_write_dxy   (upd_write_dxy),
    .upd_move        (upd_move),
    .check_collision (check_collision),
    .frame_done      (frame_done),
    .busy            (busy),
    .overrun         (overrun)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  // Output bundle: {valid, index, write_xy, write_dxy, move, check, done, busy, overrun}
  logic [8:0] act;
  assign act = {upd_valid, upd_index, upd_write_xy, upd_write_dxy, upd_move,
                check_collision, frame_done, busy, overrun};

  localparam logic [8:0] E_IDLE   = 9'b0_0_0_0_0_0_0_0_0;
  localparam logic [8:0] E_CHK    = 9'b0_0_0_0_0_1_0_1_0;
  localparam logic [8:0] E_CHK_OV = 9'b0_0_0_0_0_1_0_1_1;
  localparam logic [8:0] E_DONE   = 9'b0_0_0_0_0_0_1_1_0;
  localparam logic [8:0] E_S0M    = 9'b1_0_0_0_1_0_0_1_0;
  localparam logic [8:0] E_S1M    = 9'b1_1_0_0_1_0_0_1_0;
  localparam logic [8:0] E_S1E    = 9'b1_1_0_0_0_0_0_1_0;
  localparam logic [8:0] E_X0     = 9'b1_0_1_0_0_0_0_1_0;
  localparam logic [8:0] E_X1     = 9'b1_1_1_0_0_0_0_1_0;
  localparam logic [8:0] E_D0     = 9'b1_0_0_1_0_0_0_1_0;

  int n_cmp = 0;
  int n_bad = 0;

  typedef struct {
    logic       tick;
    logic [1:0] wxy, wdxy, en;
    logic [8:0] exp;
  } vec_t;

  vec_t vq[$];

  task automatic add(input logic t, input logic [1:0] wxy, input logic [1:0] wdxy,
                     input logic [1:0] en, input logic [8:0] exp);
    vec_t v;
    v.tick = t; v.wxy = wxy; v.wdxy = wdxy; v.en = en; v.exp = exp;
    vq.push_back(v);
  endtask

  task automatic drive(input logic t, input logic [1:0] wxy, input logic [1:0] wdxy,
                       input logic [1:0] en);
    frame_tick    = t;
    write_xy_req  = wxy;
    write_dxy_req = wdxy;
    enable_update = en;
  endtask

  task automatic check(input string name, input logic [8:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %b want %b (v idx xy dxy mv chk dn busy ov)", name, act, exp);
    end
  endtask

  // Reference model: a frame is the ordered list of qualifying sprite slots
  // followed by a check beat and a done beat; between frames one pending
  // sprite is drained per two cycles. m_kind: 0 idle, 1 load, 2 scan, 3 check, 4 done.
  int           m_kind, m_idx;
  logic [N-1:0] m_pxy, m_pdxy;
  logic         m_tp;
  logic [8:0]   m_exp;

  function automatic int next_slot(input int prev, input logic [N-1:0] q);
    for (int j = prev + 1; j < N; j++) if (q[j]) return j;
    return N;
  endfunction

  task automatic model_reset();
    m_kind = 0; m_idx = 0; m_pxy = '0; m_pdxy = '0; m_tp = 1'b0; m_exp = '0;
  endtask

  task automatic model_edge();
    logic [N-1:0] q;
    int           nk, ni;
    logic         st, v, ov;
`ifdef GAME_SCHED_SKIP_DISABLED_EN
    q = enable_update | m_pxy | m_pdxy;
`else
    q = '1;
`endif
    ov = frame_tick & m_tp;
    st = (m_kind == 0 && (frame_tick || m_tp)) || (m_kind == 4 && m_tp);
    nk = 0; ni = 0;
    if (st) begin
      ni = next_slot(-1, q); nk = (ni < N) ? 2 : 3;
    end else if (m_kind == 0 && (m_pxy | m_pdxy) != '0) begin
      ni = next_slot(-1, m_pxy | m_pdxy); nk = 1;
    end else if (m_kind == 2) begin
      ni = next_slot(m_idx, q); nk = (ni < N) ? 2 : 3;
    end else if (m_kind == 3) begin
      nk = 4;
    end
    v = (nk == 1) || (nk == 2);
    if (!v) ni = 0;
    m_exp = {v, 1'(ni), v & m_pxy[ni], v & m_pdxy[ni],
             (nk == 2) & enable_update[ni] & ~m_pxy[ni],
             nk == 3, nk == 4, nk != 0, ov};
    if (v) begin m_pxy[ni] = 1'b0; m_pdxy[ni] = 1'b0; end
    m_pxy  = m_pxy | write_xy_req;
    m_pdxy = m_pdxy | write_dxy_req;
    m_tp   = st ? 1'b0 : (frame_tick ? 1'b1 : m_tp);
    m_kind = nk; m_idx = ni;
  endtask

  initial begin
    // Plain frame, all sprites moving: 4 busy cycles.
    add(1, 2'b00, 2'b00, 2'b11, E_S0M);
    add(0, 2'b00, 2'b00, 2'b11, E_S1M);
    add(0, 2'b00, 2'b00, 2'b11, E_CHK);
    add(0, 2'b00, 2'b00, 2'b11, E_DONE);
    add(0, 2'b00, 2'b00, 2'b11, E_IDLE);
    // Position load for sprite 1 outside a frame.
    add(0, 2'b10, 2'b00, 2'b11, E_IDLE);
    add(0, 2'b00, 2'b00, 2'b11, E_X1);
    add(0, 2'b00, 2'b00, 2'b11, E_IDLE);
    add(0, 2'b00, 2'b00, 2'b11, E_IDLE);
    // Tick beats LOAD; the position load suppresses the move of sprite 0.
    add(0, 2'b01, 2'b00, 2'b11, E_IDLE);
    add(1, 2'b00, 2'b00, 2'b11, E_X0);
    add(0, 2'b00, 2'b00, 2'b11, E_S1M);
    add(0, 2'b00, 2'b00, 2'b11, E_CHK);
    add(0, 2'b00, 2'b00, 2'b11, E_DONE);
    add(0, 2'b00, 2'b00, 2'b11, E_IDLE);
    // Tick during the second slot: back-to-back frames, no overrun.
    add(1, 2'b00, 2'b00, 2'b11, E_S0M);
    add(0, 2'b00, 2'b00, 2'b11, E_S1M);
    add(1, 2'b00, 2'b00, 2'b11, E_CHK);
    add(0, 2'b00, 2'b00, 2'b11, E_DONE);
    add(0, 2'b00, 2'b00, 2'b11, E_S0M);
    add(0, 2'b00, 2'b00, 2'b11, E_S1M);
    add(0, 2'b00, 2'b00, 2'b11, E_CHK);
    add(0, 2'b00, 2'b00, 2'b11, E_DONE);
    add(0, 2'b00, 2'b00, 2'b11, E_IDLE);
    // Two extra ticks in one frame: second one overruns, one extra frame.
    add(1, 2'b00, 2'b00, 2'b11, E_S0M);
    add(1, 2'b00, 2'b00, 2'b11, E_S1M);
    add(1, 2'b00, 2'b00, 2'b11, E_CHK_OV);
    add(0, 2'b00, 2'b00, 2'b11, E_DONE);
    add(0, 2'b00, 2'b00, 2'b11, E_S0M);
    add(0, 2'b00, 2'b00, 2'b11, E_S1M);
    add(0, 2'b00, 2'b00, 2'b11, E_CHK);
    add(0, 2'b00, 2'b00, 2'b11, E_DONE);
    add(0, 2'b00, 2'b00, 2'b11, E_IDLE);
    add(0, 2'b00, 2'b00, 2'b11, E_IDLE);
    // Velocity load for sprite 0.
    add(0, 2'b00, 2'b01, 2'b01, E_IDLE);
    add(0, 2'b00, 2'b00, 2'b01, E_D0);
    add(0, 2'b00, 2'b00, 2'b01, E_IDLE);
    // Request on the edge of its own slot stays pending; sprite 1 disabled.
    add(0, 2'b01, 2'b00, 2'b01, E_IDLE);
    add(1, 2'b01, 2'b00, 2'b01, E_X0);
`ifdef GAME_SCHED_SKIP_DISABLED_EN
    add(0, 2'b00, 2'b00, 2'b01, E_CHK);
    add(0, 2'b00, 2'b00, 2'b01, E_DONE);
    add(0, 2'b00, 2'b00, 2'b01, E_IDLE);
    add(0, 2'b00, 2'b00, 2'b01, E_X0);
    add(0, 2'b00, 2'b00, 2'b01, E_IDLE);
    add(1, 2'b00, 2'b00, 2'b00, E_CHK);
    add(0, 2'b00, 2'b00, 2'b00, E_DONE);
    add(0, 2'b00, 2'b00, 2'b00, E_IDLE);
`else
    add(0, 2'b00, 2'b00, 2'b01, E_S1E);
    add(0, 2'b00, 2'b00, 2'b01, E_CHK);
    add(0, 2'b00, 2'b00, 2'b01, E_DONE);
    add(0, 2'b00, 2'b00, 2'b01, E_IDLE);
    add(0, 2'b00, 2'b00, 2'b01, E_X0);
    add(0, 2'b00, 2'b00, 2'b01, E_IDLE);
`endif

    reset = 1'b1;
    drive(0, 2'b00, 2'b00, 2'b00);
    repeat (2) @(negedge clk);
    check("reset_state", E_IDLE);
    reset = 1'b0;

    for (int i = 0; i < vq.size(); i++) begin
      drive(vq[i].tick, vq[i].wxy, vq[i].wdxy, vq[i].en);
      @(negedge clk);
      check($sformatf("vec%0d", i), vq[i].exp);
    end

    // Reset in the middle of a frame with a load still pending for sprite 1.
    drive(1, 2'b10, 2'b00, 2'b11);
    @(posedge clk);
    #1;
    check("pre_reset_slot", E_S0M);
    drive(0, 2'b00, 2'b00, 2'b11);
    #1 reset = 1'b1;
    #1;
    check("async_reset_outputs", E_IDLE);
    @(negedge clk);
    reset = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check($sformatf("post_reset%0d", i), E_IDLE);
    end

    // Randomized traffic against the model; DUT and model both start from reset.
    model_reset();
    for (int c = 0; c < 800; c++) begin
      drive($urandom_range(0, 5) == 0,
            ($urandom_range(0, 3) == 0) ? 2'($urandom) : 2'b00,
            ($urandom_range(0, 3) == 0) ? 2'($urandom) : 2'b00,
            ($urandom_range(0, 15) == 0) ? 2'($urandom) : enable_update);
      @(posedge clk);
      model_edge();
      @(negedge clk);
      check($sformatf("rand%0d", c), m_exp);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
